serial_odd_parity_checker: RTL

- Receive-side counterpart of the serial odd-parity generator: accepts a frame of WIDTH data bits (LSB first) followed by one parity bit, one bit per qualified clock.
- Reassembles the data word, checks that data plus parity contains an odd number of ones, and reports the result with a one-cycle done pulse.
- Keeps a saturating error counter for link-quality monitoring.
- Sits between the serial link and the consumer of parallel words.

---
 rtl/serial_odd_parity_checker_pkg.sv | 17 +
 rtl/serial_odd_parity_checker.sv | 106 ++++++++++
 2 files changed

// File: rtl/serial_odd_parity_checker_pkg.sv
// Shared types and constants for the serial odd-parity link.
// Holds the FSM state type, parity-state constants and default width.
package serial_odd_parity_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Running-parity encoding, common to generator and checker
  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  localparam int DEFAULT_WIDTH = 3;

endpackage

// File: rtl/serial_odd_parity_checker.sv
// Serial odd-parity checker: WIDTH data bits LSB first, then parity.
// Ports: clk, reset (sync, high), start, bit_in, bit_valid in;
//   busy, done, data_out, parity_err, err_count (saturating) out.
module serial_odd_parity_checker
  import serial_odd_parity_checker_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     data_out,
  output logic                 parity_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 p_q, p_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 done_q, done_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    data_d  = data_q;
    perr_d  = perr_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        // a bit arriving with start is deliberately dropped
        if (start) begin
          p_d     = EVEN;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CNT_W'(i)) sr_d[i] = bit_in;
          end
          p_d   = p_q ^ bit_in;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = PARITY;
        end
      end
      PARITY: begin
        if (bit_valid) begin
          data_d  = sr_q;
          // odd total of ones means the frame is good
          perr_d  = ~(p_q ^ bit_in);
          done_d  = 1'b1;
          if (perr_d && (err_q != ERR_MAX))
            err_d = err_q + ERR_CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      p_q     <= EVEN;
      data_q  <= '0;
      perr_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign data_out   = data_q;
  assign parity_err = perr_q;
  assign err_count  = err_q;

endmodule
